// File: rtl/cpu_pkg.sv
// Shared execute-stage types: multiplier FSM states and word/double-word datapath types.
package cpu_pkg;

    localparam int MUL_W = 16;

    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;

    typedef logic [MUL_W-1:0]   word_t;
    typedef logic [2*MUL_W-1:0] dword_t;

endpackage

// File: rtl/add16_cin_cout.sv
// 16-bit carry-lookahead adder with carry-in and carry-out.
// Carries are looked ahead within 5/5/6-bit slices; slice carries chain between slices.
module add16_cin_cout
    import cpu_pkg::*;
(
    input  word_t A,
    input  word_t B,
    input  logic  cin,
    output word_t R,
    output logic  cout
);

    word_t         w_g;
    word_t         w_p;
    logic [MUL_W:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Each carry is expanded from its own slice's carry-in, never from the previous bit.
    always_comb begin
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < MUL_W; i++) begin
            logic v_t;
            int   v_base;
            v_base = (i < 5) ? 0 : ((i < 10) ? 5 : 10);
            v_t    = w_c[v_base];
            for (int j = 0; j < MUL_W; j++) begin
                if (j >= v_base && j <= i) begin
                    v_t = w_g[j] | (w_p[j] & v_t);
                end
            end
            w_c[i+1] = v_t;
        end
    end

    assign R    = w_p ^ w_c[MUL_W-1:0];
    assign cout = w_c[MUL_W];

endmodule

// File: rtl/shift_add_multiplier_16.sv
// Iterative unsigned shift-and-add multiplier: one adder pass per clock, WIDTH clocks per product.
// Handshake: start is accepted whenever busy=0 (IDLE or DONE); done pulses for one cycle with product valid.
module shift_add_multiplier_16
    import cpu_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output mul_state_t         dbg_state
);

    localparam int                CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    mul_state_t         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_next;
    logic               w_load;

    assign w_addend = r_q[0] ? r_mcand : '0;

    add16_cin_cout u_add (
        .A   (r_acc),
        .B   (w_addend),
        .cin (1'b0),
        .R   (w_sum),
        .cout(w_cout)
    );

    // The carry-out becomes the top bit of the accumulator after the right shift.
    assign w_next = {w_cout, w_sum, r_q[WIDTH-1:1]};
    assign w_load = start && (r_state != MUL_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= MUL_IDLE;
            r_mcand   <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            if (w_load) begin
                r_state <= MUL_RUN;
                r_mcand <= A;
                r_q     <= B;
                r_acc   <= '0;
                r_count <= '0;
            end else if (r_state == MUL_RUN) begin
                r_acc   <= w_next[2*WIDTH-1:WIDTH];
                r_q     <= w_next[WIDTH-1:0];
                r_count <= r_count + 1'b1;
                if (r_count == LAST) begin
                    r_state   <= MUL_DONE;
                    r_product <= w_next;
                end
            end else begin
                r_state <= MUL_IDLE;
            end
        end
    end

    assign busy      = (r_state == MUL_RUN);
    assign done      = (r_state == MUL_DONE);
    assign product   = r_product;
    assign dbg_state = r_state;

endmodule

// File: doc/shift_add_multiplier_16.md
Name: shift_add_multiplier_16

Overview:
- Iterative unsigned multiplier for the CPU execute stage; takes two 16-bit operands and returns a 32-bit product.
- Sits directly downstream of the register-file read and reuses a 16-bit carry-lookahead add with carry-out, one add per clock (shift-and-add).
- Gives the ALU a MUL result without a combinational array multiplier; the control unit stalls on `busy` until `done`.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH. Only 16 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- A  input  WIDTH  multiplicand, captured at accepted start
- B  input  WIDTH  multiplier, captured at accepted start
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  result; held stable from done until the next accepted start

Behaviour:
- Reset (rst_n=0, asynchronous) values:
  - state=IDLE, busy=0, done=0, product=0, count=0.
  - All internal registers clear.
- States:
  - IDLE: start=1 -> load, go to RUN.
  - RUN: perform WIDTH iterations, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. If start=1 in DONE, load and go straight to RUN (back-to-back; done still pulses this cycle).
- Load (edge N, start accepted):
  - mcand<=A; Q<=B; acc<=0 (WIDTH bits); carry<=0; count<=0.
  - busy goes high after edge N.
- Each RUN edge:
  - {cout,sum} = acc + (Q[0] ? mcand : 0), computed by the adder sub-module with cin=0.
  - {acc,Q} <= {cout,sum,Q} >> 1, a (2*WIDTH+1)-bit right shift.
  - count<=count+1.
  - On the edge where count==WIDTH-1: state<=DONE, product<={next acc, next Q}.
- Latency:
  - Start accepted at edge N; done=1 and product valid in the cycle after edge N+WIDTH, i.e. WIDTH cycles.
  - busy=1 for exactly WIDTH cycles.
- Arithmetic rules:
  - Unsigned only; no overflow is possible (result fits in 2*WIDTH bits).
  - Carry-out must be retained in every iteration; dropping it corrupts results with large operands.
- Boundary conditions:
  - start while busy=1: ignored. Operands are not re-sampled and the result is unaffected.
  - A or B changing during RUN: no effect.
  - rst_n asserted mid-RUN: immediate return to IDLE with all outputs 0; no done pulse.
  - Operand 0: still takes WIDTH cycles; no early termination.
  - count width: $clog2(WIDTH)+1 bits; no wrap during RUN.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t
  - localparam MUL_W=16
  - typedef logic [MUL_W-1:0] word_t
  - typedef logic [2*MUL_W-1:0] dword_t
- One natural sub-module: add16_cin_cout.
  - Ports: A, B, cin, R, cout.
  - A 16-bit carry-lookahead adder with carry-out exposed, built from the team's 5/5/6 CLA slices.
  - Instantiated once in the datapath.
- FSM and shift registers live in the top module.

Test Plan:
- Reset held, then released, start=1 with A=3, B=5 at edge N -> busy=1 for 16 cycles; done pulse after edge N+16; product=0x0000000F.
- A=0xFFFF, B=0xFFFF -> product=0xFFFE0001, which exercises cout on every iteration; also A=0x8000, B=0x0002 -> 0x00010000.
- A=0x1234, B=0 and A=0, B=0xABCD -> product=0 after the full 16 cycles; done pulses once.
- start pulsed with A=7, B=7 at cycle 5 of an operation computing 0x00FF*0x0101 -> request ignored; result 0x0000FFFF; exactly one done pulse.
- rst_n driven low at cycle 8 of an operation computing 0x1000*0x0010 -> busy, done and product are 0 immediately; after release, a new start 2*3 gives 6.
- Back-to-back: start held high across DONE, with A=10, B=20 and then A=100, B=200 -> first result 200 (0x000000C8); second operation starts in the DONE cycle and gives 20000 (0x00004E20) 16 cycles later.
